pattern_bundle: RTL and testbench
=================================

Name: pattern_bundle

Overview:
- Parametrised, runtime-selectable bus pattern source; successor to the static constant-driver blocks.
- Beyond fixed constants it provides a seeded hold, an up-counter, walking-one, toggle, LFSR and a high-Z mode. All are registered and advanced by an enable.
- Used as a stimulus/filler source on datapath buses, self-test pattern generator and bus-parking driver.

Parameters:
- WIDTH, 8, bus width; legal range >= 2.
- TAPS, 8'hB8, LFSR feedback mask [WIDTH-1:0]; bit i set means pat[i] feeds the XOR.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst_n  input  1  synchronous, active-low reset.
- en  input  1  advance/sample enable; when low, all state holds.
- mode  input  3  pattern select: 0 ZERO, 1 ONE, 2 HOLD, 3 COUNT, 4 WALK1, 5 TOGGLE, 6 LFSR, 7 HIZ.
- load  input  1  reload pattern from seed (qualified by en).
- seed  input  WIDTH  initial/reload value.
- oput  output  WIDTH  pattern bus; equals pat when oe=1, all-Z when oe=0.
- wrap  output  1  registered one-cycle pulse on pattern wrap.

Behaviour:
- Interface: one clock `clk`; reset `rst_n` is synchronous and active-low. Sampled only on the rising edge of clk; no asynchronous path.
- State: pat[WIDTH-1:0], mode_q[2:0], oe, wrap.
- Reset (rst_n=0 at edge): pat=0, mode_q=ZERO, oe=1, wrap=0, so oput=0. Reset mid-pattern discards state immediately.
- en=0: pat, mode_q and oe hold; wrap=0. A mode change is not seen until en=1.
- en=1 priority: reset > mode change (mode != mode_q) > load > advance.
- Mode change: mode_q<=mode and pat is initialised; no advance occurs that cycle. Init values:
  - ZERO: 0. ONE: all-ones. HOLD, COUNT, TOGGLE: seed.
  - WALK1: 1 (bit 0 only).
  - LFSR: seed, or 1 if seed==0 (lock-up avoidance).
  - HIZ: pat holds.
- oe<=0 on entry to HIZ; oe<=1 on entry to any other mode.
- load (no mode change): pat<=seed in HOLD, COUNT, TOGGLE and WALK1 (WALK1 loads seed verbatim, any bit count). LFSR loads seed with the 0→1 substitution. load is ignored in ZERO, ONE and HIZ.
- Advance (en=1, no mode change, no load):
  - ZERO, ONE, HOLD, HIZ: hold.
  - COUNT: pat<=pat+1 modulo 2^WIDTH.
  - WALK1: rotate left, pat<={pat[WIDTH-2:0],pat[WIDTH-1]}.
  - TOGGLE: pat<=~pat.
  - LFSR: pat<={pat[WIDTH-2:0], ^(pat & TAPS)}.
- wrap asserts in the cycle pat shows the wrapped value:
  - COUNT advance from all-ones to 0.
  - WALK1 advance where pat[WIDTH-1]=1 before the shift.
  - Otherwise 0, including on load and on mode change.
- Latency: oput, wrap and the Z state all change one clock after the controlling input is sampled. There is no combinational path from inputs to outputs.
- Simultaneous mode change + load: the mode init wins and load is ignored that cycle.

Test Plan:
- Reset: drive rst_n=0 for 1 edge during COUNT at pat=8'h37 → next cycle oput=8'h00, wrap=0, oe=1. Held low across several edges: outputs stay reset.
- COUNT wrap: mode=3, seed=8'hFD, en=1 → oput FD, FE, FF, 00 on successive cycles; wrap=1 only with 00. en=0 for 2 cycles → oput frozen, wrap=0.
- WALK1 + load: mode=4 → 01, 02, …, 80, 01; wrap=1 with the 01 after 80. load with seed=8'h81 → 81, then 03.
- LFSR: WIDTH=8, TAPS=8'hB8, seed=0 → first value 01. Never reaches 00; returns to 01 after exactly 255 advances. load with seed=0 mid-run → 01.
- HIZ/TOGGLE: mode=5, seed=8'hA5 → A5, 5A, A5. Switch to mode=7 → oput all-Z next cycle with pat held. Switch to mode=5 → oput=8'hA5 again (re-init from seed).
- Priority: mode change to 2 with load=1, seed=8'h3C → 3C, wrap=0. en=0 while mode changes → no change until en=1.

Source files
------------

// File: rtl/pattern_if.sv
// Control and status bundle for pattern_bundle. The tri-state pattern bus itself
// is a plain resolved port on the block, not a member of this bundle.
interface pattern_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic [2:0]       mode;
  logic             load;
  logic [WIDTH-1:0] seed;
  logic             wrap;
  logic             oe;

  modport master (output en, mode, load, seed, input  wrap, oe);
  modport slave  (input  en, mode, load, seed, output wrap, oe);
endinterface

// File: rtl/pattern_bundle.sv
// Runtime-selectable registered bus pattern source: constants, seeded hold,
// up-counter, walking-one, toggle, LFSR and a high-Z parking mode.
module pattern_bundle #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(8'hB8)
) (
  input  logic             clk,
  input  logic             rst_n,
  pattern_if.slave         bus,
  output wire  [WIDTH-1:0] oput
);

  typedef enum logic [2:0] {
    M_ZERO   = 3'd0,
    M_ONE    = 3'd1,
    M_HOLD   = 3'd2,
    M_COUNT  = 3'd3,
    M_WALK1  = 3'd4,
    M_TOGGLE = 3'd5,
    M_LFSR   = 3'd6,
    M_HIZ    = 3'd7
  } mode_e;

  localparam logic [WIDTH-1:0] ONE_HOT0 = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] pat_q,  pat_d;
  mode_e            mode_q, mode_d;
  logic             oe_q,   oe_d;
  logic             wrap_q, wrap_d;
  mode_e            mode_in;

  // An all-zero LFSR state never leaves zero, so substitute 1.
  function automatic logic [WIDTH-1:0] lfsr_seed(input logic [WIDTH-1:0] s);
    return (s == '0) ? ONE_HOT0 : s;
  endfunction

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] p);
    return {p[WIDTH-2:0], ^(p & TAPS)};
  endfunction

  function automatic logic [WIDTH-1:0] init_val(input mode_e            m,
                                                input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] p);
    logic [WIDTH-1:0] v;
    case (m)
      M_ZERO:                    v = '0;
      M_ONE:                     v = '1;
      M_HOLD, M_COUNT, M_TOGGLE: v = s;
      M_WALK1:                   v = ONE_HOT0;
      M_LFSR:                    v = lfsr_seed(s);
      default:                   v = p;
    endcase
    return v;
  endfunction

  assign mode_in = mode_e'(bus.mode);

  always_comb begin
    pat_d  = pat_q;
    mode_d = mode_q;
    oe_d   = oe_q;
    wrap_d = 1'b0;
    if (bus.en) begin
      if (mode_in != mode_q) begin
        // A mode change only initialises; it never advances or loads.
        mode_d = mode_in;
        oe_d   = (mode_in != M_HIZ);
        pat_d  = init_val(mode_in, bus.seed, pat_q);
      end else if (bus.load) begin
        case (mode_q)
          M_HOLD, M_COUNT, M_TOGGLE, M_WALK1: pat_d = bus.seed;
          M_LFSR:                             pat_d = lfsr_seed(bus.seed);
          default:                            pat_d = pat_q;
        endcase
      end else begin
        case (mode_q)
          M_COUNT: begin
            pat_d  = pat_q + ONE_HOT0;
            wrap_d = &pat_q;
          end
          M_WALK1: begin
            pat_d  = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
            wrap_d = pat_q[WIDTH-1];
          end
          M_TOGGLE: pat_d = ~pat_q;
          M_LFSR:   pat_d = lfsr_step(pat_q);
          default:  pat_d = pat_q;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pat_q  <= '0;
      mode_q <= M_ZERO;
      oe_q   <= 1'b1;
      wrap_q <= 1'b0;
    end else begin
      pat_q  <= pat_d;
      mode_q <= mode_d;
      oe_q   <= oe_d;
      wrap_q <= wrap_d;
    end
  end

  assign oput     = oe_q ? pat_q : {WIDTH{1'bz}};
  assign bus.wrap = wrap_q;
  assign bus.oe   = oe_q;

endmodule

// File: tb/tb_pattern_bundle.sv
// Directed bench for pattern_bundle with a cycle-level behavioural reference.
module tb_pattern_bundle;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic      rst_n;
  wire [7:0] oput;
  pattern_if #(.WIDTH(8)) pif();

  pattern_bundle #(.WIDTH(8), .TAPS(8'hB8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (pif.slave),
    .oput  (oput)
  );

  localparam int TAPS_I = 'hB8;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;
  int lit_pat  = -1;
  int lit_wrap = -1;
  int lit_oe   = -1;

  // Reference state: what the outputs must show after each rising edge.
  int m_pat  = 0;
  int m_mode = 0;
  bit m_oe   = 1'b1;
  bit m_wrap = 1'b0;

  function automatic int nz(input int s);
    return (s == 0) ? 1 : s;
  endfunction

  function automatic int lfsr_next(input int p);
    int fb = 0;
    for (int i = 0; i < 8; i++)
      if (((TAPS_I >> i) & 1) == 1 && ((p >> i) & 1) == 1) fb = fb ^ 1;
    return ((p * 2) % 256) + fb;
  endfunction

  always @(posedge clk) begin
    int p;
    int md;
    bit o;
    bit w;
    p  = m_pat;
    md = m_mode;
    o  = m_oe;
    w  = 1'b0;
    if (!rst_n) begin
      p = 0; md = 0; o = 1'b1;
    end else if (pif.en) begin
      if (int'(pif.mode) != m_mode) begin
        md = int'(pif.mode);
        o  = (md != 7);
        case (md)
          0:       p = 0;
          1:       p = 255;
          2, 3, 5: p = int'(pif.seed);
          4:       p = 1;
          6:       p = nz(int'(pif.seed));
          default: p = m_pat;
        endcase
      end else if (pif.load) begin
        if (m_mode inside {2, 3, 4, 5}) p = int'(pif.seed);
        else if (m_mode == 6)           p = nz(int'(pif.seed));
      end else begin
        case (m_mode)
          3: begin w = (m_pat == 255); p = (m_pat + 1) % 256; end
          4: begin w = (m_pat >= 128); p = (m_pat * 2) % 256 + (m_pat >= 128 ? 1 : 0); end
          5: p = 255 - m_pat;
          6: p = lfsr_next(m_pat);
          default: p = m_pat;
        endcase
      end
    end
    m_pat  <= p;
    m_mode <= md;
    m_oe   <= o;
    m_wrap <= w;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      checks++;
      if (pif.oe !== m_oe) begin
        errors++;
        $display("FAIL oe: got %b expected %b at %0t", pif.oe, m_oe, $time);
      end
      checks++;
      if (pif.wrap !== m_wrap) begin
        errors++;
        $display("FAIL wrap: got %b expected %b at %0t", pif.wrap, m_wrap, $time);
      end
      if (m_oe) begin
        checks++;
        if (oput !== m_pat[7:0]) begin
          errors++;
          $display("FAIL oput: got %02h expected %02h at %0t", oput, m_pat[7:0], $time);
        end
      end
      if (m_mode == 6 && m_oe) begin
        checks++;
        if (oput === 8'h00) begin
          errors++;
          $display("FAIL lfsr_zero: got %02h expected nonzero at %0t", oput, $time);
        end
      end
      if (lit_pat >= 0) begin
        checks++;
        if (oput !== lit_pat[7:0]) begin
          errors++;
          $display("FAIL lit_oput: got %02h expected %02h at %0t", oput, lit_pat[7:0], $time);
        end
      end
      if (lit_wrap >= 0) begin
        checks++;
        if (pif.wrap !== lit_wrap[0]) begin
          errors++;
          $display("FAIL lit_wrap: got %b expected %b at %0t", pif.wrap, lit_wrap[0], $time);
        end
      end
      if (lit_oe >= 0) begin
        checks++;
        if (pif.oe !== lit_oe[0]) begin
          errors++;
          $display("FAIL lit_oe: got %b expected %b at %0t", pif.oe, lit_oe[0], $time);
        end
      end
    end
  end

  // Apply one cycle of inputs; lp/lw/lo are hand-computed expectations (-1 = none).
  task automatic drv(input bit r, input bit e, input int m, input bit l, input int s,
                     input int lp, input int lw, input int lo);
    rst_n    = r;
    pif.en   = e;
    pif.mode = 3'(m);
    pif.load = l;
    pif.seed = 8'(s);
    lit_pat  = lp;
    lit_wrap = lw;
    lit_oe   = lo;
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; pif.en = 1'b0; pif.mode = 3'd0; pif.load = 1'b0; pif.seed = 8'h00;
    chk_on = 1'b1;
    drv(0, 0, 0, 0, 0, 'h00, 0, 1);
    drv(0, 1, 3, 0, 0, 'h00, 0, 1);

    // COUNT wrap and en freeze
    drv(1, 1, 3, 0, 'hFD, 'hFD, 0, 1);
    drv(1, 1, 3, 0, 'hFD, 'hFE, 0, 1);
    drv(1, 1, 3, 0, 'hFD, 'hFF, 0, 1);
    drv(1, 1, 3, 0, 'hFD, 'h00, 1, 1);
    drv(1, 0, 3, 0, 'hFD, 'h00, 0, 1);
    drv(1, 0, 3, 0, 'hFD, 'h00, 0, 1);

    // Reset mid-pattern, then held low
    drv(1, 1, 3, 1, 'h37, 'h37, 0, 1);
    drv(0, 1, 3, 0, 'h37, 'h00, 0, 1);
    drv(0, 1, 3, 0, 'h37, 'h00, 0, 1);
    drv(0, 1, 3, 0, 'h37, 'h00, 0, 1);

    // WALK1 wrap and load
    drv(1, 1, 4, 0, 'h00, 'h01, 0, 1);
    for (int k = 1; k < 8; k++) drv(1, 1, 4, 0, 'h00, 1 << k, 0, 1);
    drv(1, 1, 4, 0, 'h00, 'h01, 1, 1);
    drv(1, 1, 4, 1, 'h81, 'h81, 0, 1);
    drv(1, 1, 4, 0, 'h81, 'h03, 1, 1);

    // LFSR period, zero-seed substitution
    drv(1, 1, 6, 0, 'h00, 'h01, 0, 1);
    drv(1, 1, 6, 0, 'h00, 'h02, 0, 1);
    drv(1, 1, 6, 0, 'h00, 'h04, 0, 1);
    for (int k = 0; k < 252; k++) drv(1, 1, 6, 0, 'h00, -1, 0, 1);
    drv(1, 1, 6, 0, 'h00, 'h01, 0, 1);
    for (int k = 0; k < 5; k++) drv(1, 1, 6, 0, 'h00, -1, 0, 1);
    drv(1, 1, 6, 1, 'h00, 'h01, 0, 1);

    // TOGGLE and HIZ parking
    drv(1, 1, 5, 0, 'hA5, 'hA5, 0, 1);
    drv(1, 1, 5, 0, 'hA5, 'h5A, 0, 1);
    drv(1, 1, 5, 0, 'hA5, 'hA5, 0, 1);
    drv(1, 1, 7, 0, 'hA5, -1, 0, 0);
    drv(1, 1, 7, 1, 'h11, -1, 0, 0);
    drv(1, 1, 5, 0, 'hA5, 'hA5, 0, 1);

    // Priority: mode init beats load; en=0 hides mode change
    drv(1, 1, 2, 1, 'h3C, 'h3C, 0, 1);
    drv(1, 0, 3, 0, 'h10, 'h3C, 0, 1);
    drv(1, 0, 3, 0, 'h10, 'h3C, 0, 1);
    drv(1, 1, 3, 0, 'h10, 'h10, 0, 1);
    drv(1, 1, 3, 0, 'h10, 'h11, 0, 1);

    // load ignored in ONE, honoured in HOLD, gated by en
    drv(1, 1, 1, 0, 'h12, 'hFF, 0, 1);
    drv(1, 1, 1, 1, 'h12, 'hFF, 0, 1);
    drv(1, 1, 2, 0, 'h55, 'h55, 0, 1);
    drv(1, 1, 2, 1, 'h66, 'h66, 0, 1);
    drv(1, 1, 2, 0, 'h77, 'h66, 0, 1);
    drv(1, 0, 2, 1, 'h99, 'h66, 0, 1);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
